// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, instruction codes and the
// sequencer state encoding used by the fetch controller and its helpers.
package y86_pkg;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam int STAGE_W = 6;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PCUPD     = 3'd6,
      S_STOP      = 3'd7
   } state_t;

   // Stage enable pattern for a state; bit 0 is fetch, bit 5 is PC update.
   function automatic logic [STAGE_W-1:0] stage_onehot(input state_t s);
      case (s)
         S_FETCH:     return 6'b000001;
         S_DECODE:    return 6'b000010;
         S_EXECUTE:   return 6'b000100;
         S_MEMORY:    return 6'b001000;
         S_WRITEBACK: return 6'b010000;
         S_PCUPD:     return 6'b100000;
         default:     return 6'b000000;
      endcase
   endfunction

   // Fetch fault resolution: an instruction-memory fault outranks a bad
   // opcode, which outranks a legitimate halt.
   function automatic stat_t fetch_fault(input logic imem_error,
                                         input logic invalid_instr,
                                         input logic halt);
      if (imem_error)         return STAT_ADR;
      else if (invalid_instr) return STAT_INS;
      else if (halt)          return STAT_HLT;
      else                    return STAT_AOK;
   endfunction

endpackage

// File: rtl/pc_select.sv
// Next-PC selection: call and taken jumps go to valC, ret to the popped
// return address, everything else falls through to valP.
module pc_select
   import y86_pkg::*;
(
   input  logic [3:0]  icode,
   input  logic        cnd,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic [63:0] valM,
   output logic [63:0] new_pc
);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves new_pc unassigned (no latch).
      new_pc = valP;
      case (icode)
         I_CALL: new_pc = valC;
         I_JXX:  if (cnd) new_pc = valC;
         I_RET:  new_pc = valM;
         default: new_pc = valP;
      endcase
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Sequential Y86-64 stage sequencer: walks one stage per cycle, owns the PC,
// the machine status and the retired-instruction counter.
module fetch_ctrl
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                go,
   input  logic [3:0]          icode,
   input  logic                cnd,
   input  logic [63:0]         valC,
   input  logic [63:0]         valP,
   input  logic [63:0]         valM,
   input  logic                halt,
   input  logic                imem_error,
   input  logic                invalid_instr,
   input  logic                dmem_error,
   input  logic                mem_wait,
   output logic [63:0]         PC,
   output logic [STAGE_W-1:0]  stage_en,
   output logic [2:0]          stat,
   output logic [31:0]         instr_count
);

   state_t      state;
   stat_t       fault;
   logic [63:0] new_pc;

   pc_select u_pc_select (
      .icode  (icode),
      .cnd    (cnd),
      .valC   (valC),
      .valP   (valP),
      .valM   (valM),
      .new_pc (new_pc)
   );

   assign fault = fetch_fault(imem_error, invalid_instr, halt);

   // stage_en is registered alongside state so it always reflects the
   // state being entered, never the raw inputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state       <= S_IDLE;
         PC          <= RESET_PC;
         stat        <= STAT_AOK;
         instr_count <= '0;
         stage_en    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  state    <= S_FETCH;
                  stage_en <= stage_onehot(S_FETCH);
               end
            end
            S_FETCH: begin
               if (fault != STAT_AOK) begin
                  state    <= S_STOP;
                  stat     <= fault;
                  stage_en <= stage_onehot(S_STOP);
               end else begin
                  state    <= S_DECODE;
                  stage_en <= stage_onehot(S_DECODE);
               end
            end
            S_DECODE: begin
               state    <= S_EXECUTE;
               stage_en <= stage_onehot(S_EXECUTE);
            end
            S_EXECUTE: begin
               state    <= S_MEMORY;
               stage_en <= stage_onehot(S_MEMORY);
            end
            S_MEMORY: begin
               // A fault reported while the memory is still busy is not yet valid.
               if (!mem_wait) begin
                  if (dmem_error) begin
                     state    <= S_STOP;
                     stat     <= STAT_ADR;
                     stage_en <= stage_onehot(S_STOP);
                  end else begin
                     state    <= S_WRITEBACK;
                     stage_en <= stage_onehot(S_WRITEBACK);
                  end
               end
            end
            S_WRITEBACK: begin
               state    <= S_PCUPD;
               stage_en <= stage_onehot(S_PCUPD);
            end
            S_PCUPD: begin
               PC          <= new_pc;
               instr_count <= instr_count + 32'd1;
               state       <= S_FETCH;
               stage_en    <= stage_onehot(S_FETCH);
            end
            default: begin
               state    <= S_STOP;
               stage_en <= stage_onehot(S_STOP);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each cycle's expected outputs are queued
// with the stimulus and compared one cycle later against the DUT.
module tb_fetch_ctrl;
   import y86_pkg::*;

   localparam logic [63:0] RST_PC = 64'h8;

   logic        clk = 1'b0;
   logic        reset, go, cnd, halt, imem_error, invalid_instr, dmem_error, mem_wait;
   logic [3:0]  icode;
   logic [63:0] valC, valP, valM;
   logic [63:0] PC;
   logic [5:0]  stage_en;
   logic [2:0]  stat;
   logic [31:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [5:0]  se;
      logic [63:0] pc;
      logic [2:0]  st;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .go            (go),
      .icode         (icode),
      .cnd           (cnd),
      .valC          (valC),
      .valP          (valP),
      .valM          (valM),
      .halt          (halt),
      .imem_error    (imem_error),
      .invalid_instr (invalid_instr),
      .dmem_error    (dmem_error),
      .mem_wait      (mem_wait),
      .PC            (PC),
      .stage_en      (stage_en),
      .stat          (stat),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Queue the expectation for the coming edge, clock it, then retire it.
   task automatic step(input string tag, input logic [5:0] se, input logic [63:0] pc,
                       input logic [2:0] st, input logic [31:0] cnt);
      exp_t e;
      e.tag = tag; e.se = se; e.pc = pc; e.st = st; e.cnt = cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".stage_en"}, 64'(stage_en), 64'(e.se));
      check({e.tag, ".pc"}, PC, e.pc);
      check({e.tag, ".stat"}, 64'(stat), 64'(e.st));
      check({e.tag, ".count"}, 64'(instr_count), 64'(e.cnt));
   endtask

   task automatic clear_inputs();
      go = 0; cnd = 0; halt = 0; imem_error = 0; invalid_instr = 0;
      dmem_error = 0; mem_wait = 0; icode = I_NOP;
      valC = '0; valP = '0; valM = '0;
   endtask

   task automatic restart(input string tag);
      clear_inputs();
      reset = 1;
      step({tag, "_rst"}, 6'd0, RST_PC, 3'd1, 32'd0);
      reset = 0;
      go = 1;
      step({tag, "_go"}, 6'd1, RST_PC, 3'd1, 32'd0);
   endtask

   // Runs one full instruction starting with the DUT already in FETCH; go is
   // held high throughout to show it is ignored outside IDLE.
   task automatic run_instr(input string tag, input logic [3:0] ic, input logic c,
                            input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
                            input logic [63:0] pc0, input logic [31:0] cnt0,
                            input logic [63:0] pc1);
      go = 1; icode = ic; cnd = c; valC = vc; valP = vp; valM = vm;
      step({tag, "_dec"}, 6'd2,  pc0, 3'd1, cnt0);
      step({tag, "_exe"}, 6'd4,  pc0, 3'd1, cnt0);
      step({tag, "_mem"}, 6'd8,  pc0, 3'd1, cnt0);
      step({tag, "_wb"},  6'd16, pc0, 3'd1, cnt0);
      step({tag, "_pcu"}, 6'd32, pc0, 3'd1, cnt0);
      step({tag, "_ret"}, 6'd1,  pc1, 3'd1, cnt0 + 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_inputs();
      reset = 1;
      step("reset", 6'd0, RST_PC, 3'd1, 32'd0);
      reset = 0;
      step("idle_hold", 6'd0, RST_PC, 3'd1, 32'd0);
      go = 1;
      step("go", 6'd1, RST_PC, 3'd1, 32'd0);

      run_instr("nop",    I_NOP,    1'b0, 64'h77,  64'd10,  64'h99,  RST_PC,  32'd0, 64'd10);
      run_instr("jxx_t",  I_JXX,    1'b1, 64'h40,  64'h4A,  64'h5,   64'd10,  32'd1, 64'h40);
      run_instr("jxx_nt", I_JXX,    1'b0, 64'h300, 64'h49,  64'h5,   64'h40,  32'd2, 64'h49);
      run_instr("ret",    I_RET,    1'b1, 64'h7,   64'h51,  64'h100, 64'h49,  32'd3, 64'h100);
      run_instr("call",   I_CALL,   1'b0, 64'h200, 64'h109, 64'h3,   64'h100, 32'd4, 64'h200);
      run_instr("cmov",   I_RRMOVQ, 1'b1, 64'h500, 64'h18,  64'h600, 64'h200, 32'd5, 64'h18);

      // Halt in FETCH at PC 0x18, then STOP must ignore everything but reset.
      clear_inputs();
      halt = 1;
      step("halt", 6'd0, 64'h18, 3'd2, 32'd6);
      for (int i = 0; i < 20; i++) begin
         go = i[0]; halt = i[1]; mem_wait = i[2]; dmem_error = i[3];
         step("stop_hold", 6'd0, 64'h18, 3'd2, 32'd6);
      end

      restart("adr");
      imem_error = 1; invalid_instr = 1; halt = 1;
      step("prio_adr", 6'd0, RST_PC, 3'd3, 32'd0);

      restart("ins");
      invalid_instr = 1; halt = 1;
      step("prio_ins", 6'd0, RST_PC, 3'd4, 32'd0);

      // Memory wait for three cycles with a premature fault, then the real fault.
      restart("dmem");
      step("dmem_dec", 6'd2, RST_PC, 3'd1, 32'd0);
      step("dmem_exe", 6'd4, RST_PC, 3'd1, 32'd0);
      mem_wait = 1; dmem_error = 1;
      step("dmem_mem0", 6'd8, RST_PC, 3'd1, 32'd0);
      for (int i = 0; i < 3; i++) step("dmem_wait", 6'd8, RST_PC, 3'd1, 32'd0);
      mem_wait = 0;
      step("dmem_stop", 6'd0, RST_PC, 3'd3, 32'd0);
      step("dmem_hold", 6'd0, RST_PC, 3'd3, 32'd0);

      // Reset during a memory wait after one retired instruction.
      restart("mwrst");
      run_instr("mwrst_nop", I_NOP, 1'b0, 64'h1, 64'h30, 64'h2, RST_PC, 32'd0, 64'h30);
      step("mwrst_dec", 6'd2, 64'h30, 3'd1, 32'd1);
      step("mwrst_exe", 6'd4, 64'h30, 3'd1, 32'd1);
      mem_wait = 1;
      step("mwrst_mem", 6'd8, 64'h30, 3'd1, 32'd1);
      step("mwrst_wait", 6'd8, 64'h30, 3'd1, 32'd1);
      reset = 1;
      step("mwrst_reset", 6'd0, RST_PC, 3'd1, 32'd0);
      reset = 0; mem_wait = 0; go = 0;
      step("mwrst_idle", 6'd0, RST_PC, 3'd1, 32'd0);

      // Reset while in PCUPD must not load the selected PC.
      restart("pcrst");
      valP = 64'h70;
      step("pcrst_dec", 6'd2,  RST_PC, 3'd1, 32'd0);
      step("pcrst_exe", 6'd4,  RST_PC, 3'd1, 32'd0);
      step("pcrst_mem", 6'd8,  RST_PC, 3'd1, 32'd0);
      step("pcrst_wb",  6'd16, RST_PC, 3'd1, 32'd0);
      step("pcrst_pcu", 6'd32, RST_PC, 3'd1, 32'd0);
      reset = 1;
      step("pcrst_reset", 6'd0, RST_PC, 3'd1, 32'd0);
      reset = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
